// File: rtl/ram_sdp_rr_arbiter.sv
// Round-robin front end for a 2048x8 simple-dual-port block RAM shared by two
// writers and two readers. The write and read sides each have an independent
// two-way round-robin arbiter. All RAM-facing pins are registered. Read data
// comes back two cycles after the request sample, tagged by a per-reader valid.
// Optional build macro RAM_ARB_WR_BYPASS_EN: a read that hits the address being
// written in the same cycle returns the new write data instead of the old RAM data.
module ram_sdp_rr_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int RR_INIT = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        W_REQ,
  input  logic [ADDR_W-1:0] W_ADDR0,
  input  logic [ADDR_W-1:0] W_ADDR1,
  input  logic [DATA_W-1:0] W_DATA0,
  input  logic [DATA_W-1:0] W_DATA1,
  output logic [1:0]        W_GNT,
  input  logic [1:0]        R_REQ,
  input  logic [ADDR_W-1:0] R_ADDR0,
  input  logic [ADDR_W-1:0] R_ADDR1,
  output logic [1:0]        R_GNT,
  output logic [1:0]        R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic              RAM_WEN,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WD,
  output logic              RAM_REN,
  output logic [ADDR_W-1:0] RAM_RADDR,
  input  logic [DATA_W-1:0] RAM_RD
);

  localparam logic PTR_INIT = (RR_INIT != 0);

  // Winner index among eligible requesters; the pointer only breaks ties.
  function automatic logic rr_pick(input logic [1:0] elig, input logic ptr);
    return (&elig) ? ptr : elig[1];
  endfunction

  logic       w_ptr_p0;
  logic       r_ptr_p0;
  logic [1:0] w_elig_p0;
  logic [1:0] r_elig_p0;
  logic       w_any_p0;
  logic       r_any_p0;
  logic       w_sel_p0;
  logic       r_sel_p0;

  // Stage p0: mask out a requester during its own grant cycle, then pick a winner
  always_comb begin
    w_elig_p0 = W_REQ & ~W_GNT;
    r_elig_p0 = R_REQ & ~R_GNT;
    w_any_p0  = |w_elig_p0;
    r_any_p0  = |r_elig_p0;
    w_sel_p0  = rr_pick(w_elig_p0, w_ptr_p0);
    r_sel_p0  = rr_pick(r_elig_p0, r_ptr_p0);
  end

  // Stage p1 (write): register grant and RAM write pins; pointer passes to the loser
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      W_GNT     <= 2'b00;
      RAM_WEN   <= 1'b0;
      RAM_WADDR <= '0;
      RAM_WD    <= '0;
      w_ptr_p0  <= PTR_INIT;
    end else begin
      W_GNT   <= {w_any_p0 & w_sel_p0, w_any_p0 & ~w_sel_p0};
      RAM_WEN <= w_any_p0;
      if (w_any_p0) begin
        RAM_WADDR <= w_sel_p0 ? W_ADDR1 : W_ADDR0;
        RAM_WD    <= w_sel_p0 ? W_DATA1 : W_DATA0;
        w_ptr_p0  <= ~w_sel_p0;
      end
    end
  end

  // Stage p1 (read): register grant and RAM read pins; stage p2: valid follows grant
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      R_GNT     <= 2'b00;
      R_VALID   <= 2'b00;
      RAM_REN   <= 1'b0;
      RAM_RADDR <= '0;
      r_ptr_p0  <= PTR_INIT;
    end else begin
      R_GNT   <= {r_any_p0 & r_sel_p0, r_any_p0 & ~r_sel_p0};
      R_VALID <= R_GNT;
      RAM_REN <= r_any_p0;
      if (r_any_p0) begin
        RAM_RADDR <= r_sel_p0 ? R_ADDR1 : R_ADDR0;
        r_ptr_p0  <= ~r_sel_p0;
      end
    end
  end

`ifdef RAM_ARB_WR_BYPASS_EN
  logic              byp_vld_p2;
  logic [DATA_W-1:0] byp_data_p2;

  // Stage p2: remember a same-cycle write/read collision and the data being written
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byp_vld_p2  <= 1'b0;
      byp_data_p2 <= '0;
    end else begin
      byp_vld_p2  <= RAM_WEN & RAM_REN & (RAM_WADDR == RAM_RADDR);
      byp_data_p2 <= RAM_WD;
    end
  end

  assign R_DATA = byp_vld_p2 ? byp_data_p2 : RAM_RD;
`else
  assign R_DATA = RAM_RD;
`endif

endmodule

// File: doc/ram_sdp_rr_arbiter.md
Name: ram_sdp_rr_arbiter

Overview:
- Shares one 2048x8 simple-dual-port block RAM between two write requesters (W0, W1) and two read requesters (R0, R1), all on one clock.
- The write side and the read side are arbitrated independently, each with its own round-robin pointer.
- All RAM-facing signals are registered and drive the RAM's WD/WADDR/WEN and RADDR/REN pins. RAM read data is returned to the requester that was granted, tagged with a per-requester valid.
- The RAM instance's WCLK and RCLK are both tied to CLK.

Parameters:
- ADDR_W, 11, RAM address width (2048 words).
- DATA_W, 8, RAM data width.
- RR_INIT, 0, requester index preferred first after reset (0 or 1), same value for both sides.

Ports:
- CLK  in  1  single system clock; also drives RAM WCLK/RCLK.
- RST_N  in  1  asynchronous active-low reset.
- W_REQ  in  2  write request per requester; held until W_GNT seen.
- W_ADDR0, W_ADDR1  in  ADDR_W  write address per requester; stable while W_REQ is high.
- W_DATA0, W_DATA1  in  DATA_W  write data per requester; stable while W_REQ is high.
- W_GNT  out  2  one-cycle write grant pulse.
- R_REQ  in  2  read request per requester.
- R_ADDR0, R_ADDR1  in  ADDR_W  read address per requester.
- R_GNT  out  2  one-cycle read grant pulse.
- R_VALID  out  2  read data valid, per requester.
- R_DATA  out  DATA_W  read data, shared by both readers; qualified by R_VALID.
- RAM_WEN  out  1  to RAM WEN.
- RAM_WADDR  out  ADDR_W  to RAM WADDR.
- RAM_WD  out  DATA_W  to RAM WD.
- RAM_REN  out  1  to RAM REN.
- RAM_RADDR  out  ADDR_W  to RAM RADDR.
- RAM_RD  in  DATA_W  from RAM RD; flow-through, valid the cycle after the address edge.

Behaviour:
- Reset (async assert, sync release):
  - W_GNT, R_GNT, R_VALID, RAM_WEN, RAM_REN = 0.
  - RAM_WADDR, RAM_RADDR, RAM_WD = 0.
  - Both round-robin pointers = RR_INIT.
  - A read in flight is discarded; no R_VALID is produced for it after reset.
- Eligibility at each edge: requester i is eligible iff REQ[i]=1 and GNT[i]=0 in the current cycle. This masks the stale request a requester still holds during its own grant cycle, so no double grant occurs.
- Selection per side:
  - Neither eligible: no grant; RAM_WEN (or RAM_REN) = 0 in the next cycle.
  - One eligible: it wins.
  - Both eligible: the requester the pointer points to wins.
  - After any grant, the pointer moves to the other requester. With no grant, the pointer holds.
- Write timing:
  - W_REQ[i] sampled at edge E.
  - In cycle E..E+1: W_GNT[i]=1, RAM_WEN=1, RAM_WADDR/RAM_WD = requester i's values.
  - The RAM writes at edge E+1. Write latency is 1 cycle from sample to the RAM write edge.
- Read timing:
  - R_REQ[i] sampled at edge E.
  - In cycle E..E+1: R_GNT[i]=1, RAM_REN=1, RAM_RADDR = R_ADDRi.
  - RAM samples at E+1.
  - In cycle E+1..E+2: R_VALID[i]=1 and R_DATA = RAM_RD (combinational pass-through of the RAM output).
  - Total: 2 cycles from request sample to data.
- R_VALID is a one-hot-or-zero one-cycle pulse. It is a registered copy of R_GNT, cleared by reset.
- Throughput:
  - Each side completes 1 access per cycle when both requesters alternate.
  - A single continuous requester gets a grant every 2nd cycle because of the mask.
- Write and read to the same address in the same cycle: the RAM returns OLD data (write-first is not provided), unless WR_BYPASS_EN is defined.
- Write and read sides never interact except through the bypass.
- A requester that drops REQ before its grant is simply not served. This is legal, and no pointer update occurs.

Optional Feature:
- Macro RAM_ARB_WR_BYPASS_EN.
- Defined:
  - Registers a flag when RAM_WEN=1, RAM_REN=1 and RAM_WADDR==RAM_RADDR in the same cycle, plus a copy of RAM_WD.
  - In the following R_VALID cycle, R_DATA = that registered write data instead of RAM_RD. The reader sees new data.
  - Adds 1 flag flop and DATA_W data flops.
- Undefined: R_DATA = RAM_RD always, giving old-data semantics.

Test Plan:
- Reset, then W_REQ=01, W_ADDR0=0x005, W_DATA0=0xA5 -> W_GNT=01 one cycle later, RAM_WEN=1, RAM_WADDR=0x005, RAM_WD=0xA5; then R_REQ=01, R_ADDR0=0x005 -> R_GNT=01 at +1, R_VALID=01 with R_DATA=0xA5 at +2.
- W_REQ=11 held continuously, RR_INIT=0 -> W_GNT sequence 01,10,01,10; RAM_WEN high every cycle; the pointer alternates.
- R_REQ=01 held for 6 cycles -> R_GNT=01 on alternate cycles only (3 grants), no double grant, 3 R_VALID pulses each 1 cycle after the matching grant.
- Addr 0x7FF preloaded with 0x11; same cycle write 0x7FF=0x22 and read 0x7FF -> R_DATA=0x11 without the macro, 0x22 with RAM_ARB_WR_BYPASS_EN; a later read returns 0x22.
- Issue R_GNT, then assert RST_N=0 in the following cycle -> all outputs 0 immediately, no R_VALID after release, pointers = RR_INIT.
- R_REQ=10 and W_REQ=01 simultaneously, different addresses 0x000/0x400 -> both granted in the same cycle, independent pointers, no cross-blocking.
